// File: rtl/modulo_controle_jogo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : modulo_controle_jogo_pkg
// Purpose : Shared definitions for the naval-battle game controller. Holds the
//           FSM state encoding, the shot-result encoding, mode and display
//           codes, the board geometry, and helpers that turn a state/result
//           pair into the status and RGB output codes.
// Revision: 1.0 - initial release
// ============================================================================
package modulo_controle_jogo_pkg;

  localparam int ROWS = 7;
  localparam int COLS = 5;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_POSITION = 3'd1,
    S_AIM_ROW  = 3'd2,
    S_AIM_COL  = 3'd3,
    S_CHECK    = 3'd4,
    S_RESULT   = 3'd5,
    S_WIN      = 3'd6,
    S_LOSE     = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    RES_MISS   = 2'd0,
    RES_HIT    = 2'd1,
    RES_REPEAT = 2'd2
  } result_t;

  localparam logic [1:0] c_MODE_IDLE = 2'b00;
  localparam logic [1:0] c_MODE_POS  = 2'b01;
  localparam logic [1:0] c_MODE_ATK  = 2'b10;

  localparam logic [3:0] c_ST_IDLE   = 4'd0;
  localparam logic [3:0] c_ST_POS    = 4'd1;
  localparam logic [3:0] c_ST_AIM    = 4'd2;
  localparam logic [3:0] c_ST_HIT    = 4'd3;
  localparam logic [3:0] c_ST_MISS   = 4'd4;
  localparam logic [3:0] c_ST_REPEAT = 4'd5;
  localparam logic [3:0] c_ST_WIN    = 4'd6;
  localparam logic [3:0] c_ST_LOSE   = 4'd7;

  localparam logic [1:0] c_RGB_OFF    = 2'b00;
  localparam logic [1:0] c_RGB_MISS   = 2'b01;
  localparam logic [1:0] c_RGB_HIT    = 2'b10;
  localparam logic [1:0] c_RGB_REPEAT = 2'b11;

  function automatic logic [3:0] status_of(input state_t s, input result_t r);
    logic [3:0] v;
    v = c_ST_IDLE;
    case (s)
      S_POSITION:                   v = c_ST_POS;
      S_AIM_ROW, S_AIM_COL, S_CHECK: v = c_ST_AIM;
      S_RESULT: begin
        if (r == RES_HIT)         v = c_ST_HIT;
        else if (r == RES_REPEAT) v = c_ST_REPEAT;
        else                      v = c_ST_MISS;
      end
      S_WIN:                        v = c_ST_WIN;
      S_LOSE:                       v = c_ST_LOSE;
      default:                      v = c_ST_IDLE;
    endcase
    return v;
  endfunction

  // The result LED is lit only while a shot result is being displayed.
  function automatic logic [1:0] rgb_of(input state_t s, input result_t r);
    logic [1:0] v;
    v = c_RGB_OFF;
    if (s == S_RESULT) begin
      if (r == RES_HIT)         v = c_RGB_HIT;
      else if (r == RES_REPEAT) v = c_RGB_REPEAT;
      else                      v = c_RGB_MISS;
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/modulo_contador_coord.sv
`default_nettype none
// ============================================================================
// Module  : modulo_contador_coord
// Purpose : Wrapping coordinate counter used for the aim row and aim column.
//           Counts 0..MAX and wraps back to 0 on the increment after MAX.
// Ports   : clk      - system clock (rising edge)
//           clr      - synchronous active-high clear to 0 (dominates inc)
//           inc      - one-cycle increment request
//           o_value  - current coordinate
// Revision: 1.0 - initial release
// ============================================================================
module modulo_contador_coord #(
  parameter int MAX   = 6,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] o_value
);

  logic [WIDTH-1:0] r_value;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_value <= '0;
    end else if (inc) begin
      r_value <= (r_value == WIDTH'(MAX)) ? '0 : r_value + 1'b1;
    end
  end

  assign o_value = r_value;

endmodule
`default_nettype wire

// File: rtl/modulo_controle_jogo.sv
`default_nettype none
// ============================================================================
// Module  : modulo_controle_jogo
// Purpose : Game controller for a 7x5 naval-battle board. Sequences idle,
//           ship positioning, aiming (row then column), shot checking, timed
//           result display, and win/lose end states.
// Ports   : clk, clr           - clock / synchronous active-high reset
//           tick               - one-cycle timing pulse for result display
//           btn_confirm        - one-cycle confirm pulse
//           btn_count          - one-cycle count pulse
//           mode[1:0]          - 00 idle, 01 positioning, 10 attack
//           ship_bit, shot_bit - board cells at (at_row, at_col)
//           load_po, clr_at    - preset load / attack-matrix clear pulses
//           at_we              - attack-matrix write pulse
//           at_row, at_col     - aim coordinates
//           status[3:0], rgb   - display codes
//           shots, hits        - valid-shot and hit counters (saturating)
// Revision: 1.0 - initial release
// ============================================================================
module modulo_controle_jogo
  import modulo_controle_jogo_pkg::*;
#(
  parameter int N_SHIP       = 6,
  parameter int MAX_SHOTS    = 20,
  parameter int RESULT_TICKS = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       tick,
  input  logic       btn_confirm,
  input  logic       btn_count,
  input  logic [1:0] mode,
  input  logic       ship_bit,
  input  logic       shot_bit,
  output logic       load_po,
  output logic       clr_at,
  output logic       at_we,
  output logic [2:0] at_row,
  output logic [2:0] at_col,
  output logic [3:0] status,
  output logic [1:0] rgb,
  output logic [4:0] shots,
  output logic [4:0] hits
);

  localparam int TW = $clog2(RESULT_TICKS + 1);

  state_t          r_state, w_state_nxt;
  result_t         r_res, w_res_nxt;
  logic            r_loaded;
  logic [4:0]      r_shots, r_hits;
  logic [TW-1:0]   r_ticks;
  logic            r_load_po, r_clr_at, r_at_we;
  logic [3:0]      r_status;
  logic [1:0]      r_rgb;

  logic w_go_idle, w_arm, w_fire, w_tick_done;
  logic w_row_inc, w_col_inc, w_coord_clr;

  // Returning to idle outranks every other input except clr.
  assign w_go_idle   = (r_state != S_IDLE) && (mode == c_MODE_IDLE);
  assign w_arm       = (r_state == S_POSITION) && btn_confirm && !w_go_idle;
  assign w_fire      = (r_state == S_CHECK) && !shot_bit && !w_go_idle;
  assign w_tick_done = (r_state == S_RESULT) && tick &&
                       (r_ticks == TW'(RESULT_TICKS - 1));
  // Confirm wins over a coincident count pulse.
  assign w_row_inc   = (r_state == S_AIM_ROW) && btn_count && !btn_confirm && !w_go_idle;
  assign w_col_inc   = (r_state == S_AIM_COL) && btn_count && !btn_confirm && !w_go_idle;
  assign w_coord_clr = clr || w_arm || w_go_idle;

  modulo_contador_coord #(.MAX(ROWS - 1), .WIDTH(3)) u_row (
    .clk     (clk),
    .clr     (w_coord_clr),
    .inc     (w_row_inc),
    .o_value (at_row)
  );

  modulo_contador_coord #(.MAX(COLS - 1), .WIDTH(3)) u_col (
    .clk     (clk),
    .clr     (w_coord_clr),
    .inc     (w_col_inc),
    .o_value (at_col)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_res_nxt   = r_res;
    if (w_go_idle) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:     if (mode == c_MODE_POS) w_state_nxt = S_POSITION;
        S_POSITION: if (mode == c_MODE_ATK && r_loaded) w_state_nxt = S_AIM_ROW;
        S_AIM_ROW:  if (btn_confirm) w_state_nxt = S_AIM_COL;
        S_AIM_COL:  if (btn_confirm) w_state_nxt = S_CHECK;
        S_CHECK: begin
          w_state_nxt = S_RESULT;
          if (shot_bit)      w_res_nxt = RES_REPEAT;
          else if (ship_bit) w_res_nxt = RES_HIT;
          else               w_res_nxt = RES_MISS;
        end
        S_RESULT: begin
          // Counters were updated in CHECK, so they are final here.
          if (w_tick_done) begin
            if (r_hits == 5'(N_SHIP))          w_state_nxt = S_WIN;
            else if (r_shots == 5'(MAX_SHOTS)) w_state_nxt = S_LOSE;
            else                               w_state_nxt = S_AIM_ROW;
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Outputs are registered from the next-state decode so they change in the
  // same cycle as the state they describe.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state   <= S_IDLE;
      r_res     <= RES_MISS;
      r_loaded  <= 1'b0;
      r_shots   <= '0;
      r_hits    <= '0;
      r_ticks   <= '0;
      r_load_po <= 1'b0;
      r_clr_at  <= 1'b0;
      r_at_we   <= 1'b0;
      r_status  <= c_ST_IDLE;
      r_rgb     <= c_RGB_OFF;
    end else begin
      r_state   <= w_state_nxt;
      r_res     <= w_res_nxt;
      r_load_po <= w_arm;
      r_clr_at  <= w_arm || w_go_idle;
      r_at_we   <= w_fire;
      r_status  <= status_of(w_state_nxt, w_res_nxt);
      r_rgb     <= rgb_of(w_state_nxt, w_res_nxt);

      if (w_arm || w_go_idle) begin
        r_loaded <= w_arm;
        r_shots  <= '0;
        r_hits   <= '0;
      end else if (w_fire) begin
        if (r_shots < 5'(MAX_SHOTS))         r_shots <= r_shots + 5'd1;
        if (ship_bit && r_hits < 5'(N_SHIP)) r_hits  <= r_hits + 5'd1;
      end

      if (r_state != S_RESULT || w_go_idle || w_tick_done) begin
        r_ticks <= '0;
      end else if (tick) begin
        r_ticks <= r_ticks + 1'b1;
      end
    end
  end

  assign load_po = r_load_po;
  assign clr_at  = r_clr_at;
  assign at_we   = r_at_we;
  assign status  = r_status;
  assign rgb     = r_rgb;
  assign shots   = r_shots;
  assign hits    = r_hits;

endmodule
`default_nettype wire

// File: doc/modulo_controle_jogo.md
MODULO_CONTROLE_JOGO -- requirements
Module: modulo_controle_jogo

Interface
REQ-001 Parameter: N_SHIP, 6, number of ship cells in every preset layout (win threshold).
REQ-002 Parameter: MAX_SHOTS, 20, number of valid shots allowed before loss.
REQ-003 Parameter: RESULT_TICKS, 4, number of tick pulses the hit/miss result is held.
REQ-004 Port: clk  input  1  single system clock; all logic is rising-edge.
REQ-005 Port: clr  input  1  reset, synchronous and active-high.
REQ-006 Port: tick  input  1  one-cycle pulse from the frequency divider (result timing).
REQ-007 Port: btn_confirm  input  1  debounced, edge-detected one-cycle confirm pulse.
REQ-008 Port: btn_count  input  1  debounced, edge-detected one-cycle count pulse.
REQ-009 Port: mode  input  2  game-mode switches: 00 idle, 01 positioning, 10 attack, 11 reserved.
REQ-010 Port: ship_bit  input  1  position-matrix cell at (at_row, at_col), valid in the same cycle.
REQ-011 Port: shot_bit  input  1  attack-matrix cell at (at_row, at_col), valid in the same cycle.
REQ-012 Port: load_po  output  1  one-cycle pulse loading the selected preset into the position matrix.
REQ-013 Port: clr_at  output  1  one-cycle pulse clearing the attack matrix.
REQ-014 Port: at_we  output  1  one-cycle write pulse marking (at_row, at_col) as attacked.
REQ-015 Port: at_row  output  3  aim row, 0..6.
REQ-016 Port: at_col  output  3  aim column, 0..4.
REQ-017 Port: status  output  4  7-seg code: 0 idle, 1 position, 2 aim, 3 hit, 4 miss, 5 repeat, 6 win, 7 lose.
REQ-018 Port: rgb  output  2  result LED: 00 off, 01 miss, 10 hit, 11 repeat.
REQ-019 Port: shots  output  5  valid-shot counter.
REQ-020 Port: hits  output  5  hit counter.

Function
REQ-021 The FSM SHALL have states IDLE, POSITION, AIM_ROW, AIM_COL, CHECK, RESULT, WIN and LOSE.
REQ-022 IDLE: mode==01 -> POSITION next cycle; all other inputs are ignored.
REQ-023 POSITION: btn_confirm SHALL pulse load_po and clr_at in the following cycle, clear shots/hits/at_row/at_col and set a loaded flag; mode==10 with loaded set -> AIM_ROW.
REQ-024 AIM_ROW: btn_count increments at_row, wrapping 6->0; btn_confirm -> AIM_COL.
REQ-025 AIM_COL: btn_count increments at_col, wrapping 4->0; btn_confirm -> CHECK.
REQ-026 Simultaneous btn_confirm and btn_count: confirm acts and count is discarded.
REQ-027 CHECK (exactly 1 cycle): if shot_bit=1 -> repeat (no at_we, counters unchanged); otherwise pulse at_we, shots+1 and hits+1 if ship_bit=1; -> RESULT.
REQ-028 RESULT: status/rgb show hit, miss or repeat until RESULT_TICKS tick pulses are counted; buttons are ignored.
REQ-029 RESULT exit: hits==N_SHIP -> WIN; else shots==MAX_SHOTS -> LOSE; else -> AIM_ROW with at_row/at_col retained. WIN has priority over LOSE.
REQ-030 WIN/LOSE SHALL hold status 6/7 with rgb 00 until mode==00.
REQ-031 mode==00 in any non-IDLE state -> IDLE next cycle, loaded flag cleared, counters and coordinates zeroed, clr_at pulsed once.
REQ-032 Mode changes to 01 or 11 outside IDLE/POSITION SHALL be ignored.
REQ-033 status SHALL be 1 in POSITION and 2 in AIM_ROW/AIM_COL/CHECK; rgb SHALL be 00 outside RESULT.
REQ-034 shots and hits SHALL saturate and never exceed MAX_SHOTS or N_SHIP respectively.

Reset
REQ-035 clr=1 at a rising edge SHALL force IDLE, clear the loaded flag, shots, hits, at_row, at_col, and the tick counter, and drive every output to 0; clr SHALL dominate all other inputs, including mid-CHECK (no at_we is issued).

Structure
REQ-036 State encoding, status codes, rgb codes, ROWS=7 and COLS=5 SHALL live in a shared package.
REQ-037 The row/column wrap counters SHALL be one reusable sub-module, modulo_contador_coord (parameter MAX, with inc and clr inputs).

Verification
REQ-038 mode 01, confirm, mode 10 -> load_po and clr_at each high for 1 cycle, then status=2 with at_row=0 and at_col=0.
REQ-039 3 count, confirm, 2 count, confirm with ship_bit=1 and shot_bit=0 -> at_we for 1 cycle at (3,2), hits=1, shots=1, rgb=10, status=3 for 4 ticks, then AIM_ROW.
REQ-040 Re-fire at (3,2) with shot_bit=1 -> no at_we, shots remain 1, rgb=11, status=5.
REQ-041 7 count in AIM_ROW -> at_row=0 (wrap); confirm and count in the same cycle -> AIM_COL and at_row unchanged.
REQ-042 Sixth hit on the 20th shot -> WIN (status=6); 20 misses -> LOSE (status=7); mode 00 afterwards -> IDLE with counters 0.
REQ-043 clr asserted in CHECK -> no at_we, next cycle IDLE with all outputs 0.
